// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        PAYLOAD,
        CHECK,
        DONE,
        ERROR
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int MAX_WORDS      = 2 ** DEF_ADDR_WIDTH;

    function automatic int max_words(input int aw);
        return 2 ** aw;
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words and keeps the
// running XOR of every payload byte seen since the last clear.
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word_out,
    output logic [7:0]  xor_out
);

    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] asm_q, asm_d;
    logic [7:0]  xor_q, xor_d;

    // word_out/word_valid are combinational so the top can register the write
    // in the same edge that accepts the fourth byte.
    always_comb begin
        bcnt_d     = bcnt_q;
        asm_d      = asm_q;
        xor_d      = xor_q;
        word_valid = 1'b0;
        word_out   = asm_q;
        if (clear) begin
            bcnt_d = '0;
            asm_d  = '0;
            xor_d  = '0;
        end else if (byte_en) begin
            asm_d[{bcnt_q, 3'b000} +: 8] = byte_in;
            bcnt_d     = bcnt_q + 2'd1;
            xor_d      = xor_q ^ byte_in;
            word_valid = (bcnt_q == 2'(BYTES_PER_WORD - 1));
            word_out   = asm_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bcnt_q <= '0;
            asm_q  <= '0;
            xor_q  <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            asm_q  <= asm_d;
            xor_q  <= xor_d;
        end
    end

    assign xor_out = xor_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked program image, writes it
// to instruction memory from address 0 and releases the CPU only on success.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_wren,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_data,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CW   = ADDR_WIDTH + 1;
    localparam int MAXW = max_words(ADDR_WIDTH);

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [CW-1:0]         wcnt_q, wcnt_d;
    logic                  wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;

    logic        accept;
    logic        pk_clear;
    logic        pk_en;
    logic        word_valid;
    logic [31:0] word;
    logic [7:0]  xor_run;
    logic [15:0] n_len;
    logic        last_word;

    assign busy      = state_q inside {LEN_LO, LEN_HI, PAYLOAD, CHECK};
    assign rx_ready  = busy;
    assign accept    = rx_valid && rx_ready;
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);
    assign cpu_reset = (state_q != DONE);

    assign n_len     = {rx_data, len_q[7:0]};
    assign last_word = (32'(wcnt_q) + 32'd1 == 32'(len_q));
    assign pk_clear  = (state_q == LEN_LO);
    assign pk_en     = accept && (state_q == PAYLOAD);

    prog_loader_byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_en    (pk_en),
        .byte_in    (rx_data),
        .word_valid (word_valid),
        .word_out   (word),
        .xor_out    (xor_run)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        wren_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: state_d = LEN_LO;
            LEN_LO: begin
                wcnt_d = '0;
                if (accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    if (n_len == 16'd0)
                        state_d = CHECK;
                    else if (32'(n_len) > 32'(MAXW))
                        state_d = ERROR;
                    else
                        state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (word_valid) begin
                    wren_d = 1'b1;
                    addr_d = wcnt_q[ADDR_WIDTH-1:0];
                    data_d = WORD_WIDTH'(word);
                    wcnt_d = wcnt_q + CW'(1);
                    if (last_word)
                        state_d = CHECK;
                end
            end
            CHECK: begin
                if (accept)
                    state_d = (rx_data == xor_run) ? DONE : ERROR;
            end
            DONE, ERROR: begin
                if (start)
                    state_d = LEN_LO;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign imem_wren = wren_q;
    assign imem_addr = addr_q;
    assign imem_data = data_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expected writes/results
// computed from the frame contents; a negedge monitor pops and compares.
module tb_prog_loader;

    localparam int AW     = 12;
    localparam int MAXW   = 1 << AW;
    localparam int K_WR   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          start    = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic          rx_ready;
    logic          imem_wren;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;

    int          checks   = 0;
    int          failures = 0;
    exp_t        expq[$];
    logic [31:0] fw[$];
    bit          res_prev = 1'b0;

    prog_loader #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .imem_wren (imem_wren),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int k, input int a, input logic [31:0] d);
        exp_t e;
        e.kind = k;
        e.addr = AW'(a);
        e.data = d;
        return e;
    endfunction

    // Reference checksum: XOR of every payload byte of the current image.
    function automatic logic [7:0] xor_fw();
        logic [7:0] x = 8'h00;
        foreach (fw[i]) x ^= fw[i][7:0] ^ fw[i][15:8] ^ fw[i][23:16] ^ fw[i][31:24];
        return x;
    endfunction

    task automatic fill_random(input int n);
        fw.delete();
        repeat (n) fw.push_back($urandom);
    endtask

    // Monitor: every write pulse and every new done/error must match the queue head.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            res_prev = 1'b0;
        end else begin
            if (imem_wren) begin
                check("wr_expected", (expq.size() > 0 && expq[0].kind == K_WR), 1);
                if (expq.size() > 0 && expq[0].kind == K_WR) begin
                    e = expq.pop_front();
                    check("wr_addr", imem_addr, e.addr);
                    check("wr_data", imem_data, e.data);
                end
            end
            if ((done || error) && !res_prev) begin
                check("res_expected", (expq.size() > 0 && expq[0].kind != K_WR), 1);
                if (expq.size() > 0 && expq[0].kind != K_WR) begin
                    e = expq.pop_front();
                    check("res_kind", done ? K_DONE : K_ERR, e.kind);
                    check("res_cpu_reset", cpu_reset, (e.kind == K_DONE) ? 0 : 1);
                    check("res_exclusive", done ^ error, 1);
                end
            end
            res_prev = done || error;
        end
    end

    task automatic check_idle();
        check("idle_cpu_reset", cpu_reset, 1);
        check("idle_busy", busy, 0);
        check("idle_rx_ready", rx_ready, 0);
        check("idle_wren", imem_wren, 0);
        check("idle_addr", imem_addr, 0);
        check("idle_data", imem_data, 0);
        check("idle_flags", {done, error}, 0);
    endtask

    // Called and returns at posedge+1; optional random idle gap before the byte.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clock);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        forever begin
            @(negedge clock);
            if (rx_ready || t > 50) break;
            t++;
        end
        if (!rx_ready) check("rx_ready_wait", rx_ready, 1);
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    // From DONE/ERROR: hold a byte that must be ignored, then pulse start.
    task automatic rearm();
        @(negedge clock);
        if (done || error) begin
            rx_valid = 1'b1;
            rx_data  = 8'hA5;
            @(posedge clock);
            @(posedge clock);
            #1;
            rx_valid = 1'b0;
            start    = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
            @(negedge clock);
            check("rearm_cpu_reset", cpu_reset, 1);
            check("rearm_busy", busy, 1);
            check("rearm_flags", {done, error}, 0);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_result();
        bit seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clock);
            seen = done || error;
        end
        check("result_seen", seen, 1);
        @(negedge clock);
        check("queue_drained", expq.size(), 0);
        expq.delete();
        @(posedge clock);
        #1;
    endtask

    task automatic run_frame(input int n, input logic [7:0] chk, input bit gaps);
        logic [15:0] n16;
        logic [31:0] w;
        n16 = 16'(n);
        rearm();
        if (n > MAXW) begin
            expq.push_back(mk(K_ERR, 0, 0));
        end else begin
            for (int i = 0; i < n; i++) expq.push_back(mk(K_WR, i, fw[i]));
            expq.push_back(mk((chk == xor_fw()) ? K_DONE : K_ERR, 0, 0));
        end
        send_byte(n16[7:0], gaps);
        send_byte(n16[15:8], gaps);
        if (n <= MAXW) begin
            for (int i = 0; i < n; i++) begin
                w = fw[i];
                for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gaps);
            end
            send_byte(chk, gaps);
        end
        wait_result();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        logic [31:0] w;
        int n;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check_idle();
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rdy_first_cycle", rx_ready, 0);
        @(negedge clock);
        check("rdy_second_cycle", rx_ready, 1);
        @(posedge clock);
        #1;

        // Reference image: byte XOR of 0x00000013, 0xDEADBEEF is 0x31.
        fw.delete();
        fw.push_back(32'h0000_0013);
        fw.push_back(32'hDEAD_BEEF);
        run_frame(2, xor_fw(), 1'b0);
        run_frame(2, 8'h00, 1'b0);
        run_frame(2, xor_fw(), 1'b1);

        fw.delete();
        run_frame(0, 8'h00, 1'b0);
        run_frame(0, 8'h01, 1'b0);

        run_frame(32'h1001, 8'h00, 1'b0);
        fill_random(1);
        run_frame(1, xor_fw(), 1'b0);

        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(1, 10);
            fill_random(n);
            c = xor_fw();
            if ($urandom_range(0, 3) == 0) c ^= 8'($urandom_range(1, 255));
            run_frame(n, c, 1'($urandom_range(0, 1)));
        end

        fill_random(MAXW);
        run_frame(MAXW, xor_fw(), 1'b0);

        // Abort mid-payload: only the first completed word may be written.
        fill_random(3);
        rearm();
        expq.push_back(mk(K_WR, 0, fw[0]));
        send_byte(8'd3, 1'b0);
        send_byte(8'd0, 1'b0);
        w = fw[0];
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0);
        w = fw[1];
        for (int b = 0; b < 2; b++) send_byte(w[8*b +: 8], 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("abort_drained", expq.size(), 0);
        check_idle();
        expq.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        fill_random(1);
        run_frame(1, xor_fw(), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
